// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch requester and a data requester
// Ports: clk, rst (sync, active-high)
//   if_req/if_addr -> if_ready/if_rdata          fetch requester (read-only)
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_ready/dm_rdata   data requester
//   mem_req/mem_we/mem_addr/mem_wdata/mem_owner -> memory, mem_ack/mem_rdata <- memory
//   mem_owner: 0 = fetch, 1 = data; meaningful while mem_req is high
// Build option: define FETCH_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT back-to-back data grants.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_owner
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;
  logic pick_if;
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_limit_chk
    $error("STARVE_LIMIT must be within 1..7");
  end
`ifdef FETCH_STARVE_GUARD_EN
  logic [2:0] starve;
  always_comb pick_if = if_req && (!dm_req || starve == 3'(STARVE_LIMIT));
  // counts data grants made while fetch is waiting; any fetch grant or idle fetch line clears it
  always_ff @(posedge clk)
    if (rst) starve <= 3'd0;
    else if (state == IDLE) starve <= (if_req && !pick_if) ? starve + 3'd1 : 3'd0;
`else
  always_comb pick_if = if_req && !dm_req;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? ((if_req || dm_req) ? BUSY : IDLE) :
               state == BUSY ? (mem_ack ? RESP : BUSY) : IDLE;
    mem_req  = state == BUSY;
    if_ready = state == RESP && !mem_owner;
    dm_ready = state == RESP && mem_owner;
  end
  always_ff @(posedge clk)
    if (rst) begin
      mem_owner <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if (state == IDLE && (if_req || dm_req)) begin
        mem_owner <= !pick_if;
        mem_we    <= !pick_if && dm_we;
        mem_addr  <= pick_if ? if_addr : dm_addr;
        mem_wdata <= pick_if ? mem_wdata : dm_wdata;
      end
      if (state == BUSY && mem_ack && !mem_owner) if_rdata <= mem_rdata;
      if (state == BUSY && mem_ack && mem_owner && !mem_we) dm_rdata <= mem_rdata;
    end
endmodule
